i2c_frame_tx: RTL and testbench

I2C_FRAME_TX -- requirements
Module: i2c_frame_tx

---
 rtl/i2c_frame_tx.sv | 136 +++++++++++++
 tb/tb_i2c_frame_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_tx.sv
// i2c_frame_tx: sends one 3-byte I2C frame (address+R/W, byte 1, byte 2) framed by START/STOP.
// Optional macro I2C_ACK_CHECK_EN: a NACK sets o_ack_err and cuts the frame short to STOP.
module i2c_frame_tx #(
  parameter int CLK_DIV = 125
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [23:0] i_data,
  output logic        o_finished,
  output logic        o_ack_err,
  output logic        o_scl,
  inout  wire         o_sda
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [1:0]    r_quarter, w_quarter_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [1:0]    r_byte, w_byte_next;
  logic [23:0]   r_shift, w_shift_next;
  logic          w_qend, w_scl, w_sda_low, w_abort;

  assign w_qend = (r_cnt == LAST);
  assign o_scl  = w_scl;
  assign o_sda  = w_sda_low ? 1'b0 : 1'bz;

`ifdef I2C_ACK_CHECK_EN
  logic r_ack_err;
  // Bus level is read on the last cycle of the SCL-high ACK quarter q2.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ack_err <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_ack_err <= 1'b0;
    end else if (r_state == ACK && w_qend && r_quarter == 2'd2 && o_sda) begin
      r_ack_err <= 1'b1;
    end
  end
  assign w_abort   = r_ack_err;
  assign o_ack_err = r_ack_err;
`else
  assign w_abort   = 1'b0;
  assign o_ack_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_quarter <= w_quarter_next;
      r_bit     <= w_bit_next;
      r_byte    <= w_byte_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = w_qend ? '0 : r_cnt + 1'b1;
    w_quarter_next = w_qend ? r_quarter + 2'd1 : r_quarter;
    w_bit_next     = r_bit;
    w_byte_next    = r_byte;
    w_shift_next   = r_shift;
    w_scl          = 1'b1;
    w_sda_low      = 1'b0;
    o_finished     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next     = '0;
        w_quarter_next = '0;
        if (i_start) begin
          w_shift_next = i_data;
          w_bit_next   = '0;
          w_byte_next  = '0;
          w_state_next = START;
        end
      end
      START: begin
        w_sda_low = (r_quarter == 2'd1);
        if (w_qend && r_quarter == 2'd1) begin
          w_quarter_next = '0;
          w_state_next   = BIT;
        end
      end
      BIT: begin
        w_scl     = r_quarter[1];
        w_sda_low = ~r_shift[23];
        if (w_qend && r_quarter == 2'd3) begin
          w_shift_next = {r_shift[22:0], 1'b0};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_next = ACK;
          end
        end
      end
      ACK: begin
        w_scl = r_quarter[1];
        if (w_qend && r_quarter == 2'd3) begin
          if (r_byte == 2'd2 || w_abort) begin
            w_state_next = STOP;
          end else begin
            w_byte_next  = r_byte + 2'd1;
            w_state_next = BIT;
          end
        end
      end
      STOP: begin
        w_scl     = (r_quarter != 2'd0);
        w_sda_low = (r_quarter != 2'd2);
        if (w_qend && r_quarter == 2'd2) begin
          w_quarter_next = '0;
          w_state_next   = DONE;
        end
      end
      DONE: begin
        w_cnt_next     = '0;
        w_quarter_next = '0;
        o_finished     = 1'b1;
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_i2c_frame_tx.sv
// Scoreboard bench for i2c_frame_tx: a bus monitor with a simple ACKing slave recovers the bits of
// each frame and compares them, the finish cycle and o_ack_err against a queued reference result.
module tb_i2c_frame_tx;
  localparam int D = 2;
  localparam int FRAME_CYC = 113 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] data = '0;
  logic        finished, ack_err, scl;
  wire         sda_bus;
  logic        slave_low = 1'b0;
  logic [2:0]  nack_mask = 3'b000;

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup pu_sda (sda_bus);

  i2c_frame_tx #(.CLK_DIV(D)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_data(data),
    .o_finished(finished), .o_ack_err(ack_err), .o_scl(scl), .o_sda(sda_bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] d;
    logic [26:0] bits;
    int          nbits;
    logic        err;
    int unsigned fin_cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bytes MSB first, each followed by the slave's ACK level; a NACK ends the frame early
  // only when ACK checking is built in. Frame length counted in quarters of D cycles.
  function automatic exp_t model(input logic [23:0] d, input logic [2:0] nack, input int unsigned acc);
    exp_t e;
    int   quarters;
    e.d = d; e.bits = '0; e.nbits = 0; e.err = 1'b0;
    quarters = 2;
    for (int b = 0; b < 3; b++) begin
      for (int i = 7; i >= 0; i--) begin
        e.bits = {e.bits[25:0], d[8*(2-b)+i]};
        e.nbits++;
      end
      e.bits = {e.bits[25:0], nack[b]};
      e.nbits++;
      quarters += 36;
`ifdef I2C_ACK_CHECK_EN
      if (nack[b]) begin
        e.err = 1'b1;
        break;
      end
`endif
    end
    quarters += 3;
    e.fin_cyc = acc + quarters * D;
    return e;
  endfunction

  // Monitor + slave: a bit is taken on each SCL fall from the level seen while SCL was high.
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  int          fall_cnt = 0;
  int          ncol = 0;
  logic [26:0] col = '0;

  always @(negedge clk) begin
    logic cur_sda;
    exp_t e;
    cur_sda = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    if (!rst_n) begin
      fall_cnt = 0; ncol = 0; col = '0; slave_low = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !cur_sda) begin
        fall_cnt = 0; ncol = 0; col = '0;
      end else if (prev_scl && !scl) begin
        if (fall_cnt > 0) begin
          col = {col[25:0], prev_sda};
          ncol++;
        end
        fall_cnt++;
        slave_low = 1'b0;
        if (fall_cnt % 9 == 0 && fall_cnt <= 27) slave_low = ~nack_mask[fall_cnt/9 - 1];
      end
      if (finished) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL finish_pulse: got o_finished=1 required no frame pending (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          $display("frame data=%06h bits=%0d ack_err=%0b finish_cycle=%0d", e.d, ncol, ack_err, cyc);
          check("sda_bits", col, e.bits);
          check("bit_count", ncol, e.nbits);
          check("finish_cycle", cyc, e.fin_cyc);
          check("ack_err", ack_err, e.err);
        end
      end
    end
    prev_scl = scl;
    prev_sda = cur_sda;
  end

  task automatic wait_finish(output int unsigned fcyc);
    int n = 0;
    @(negedge clk);
    while (!finished && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL finish_timeout: got no o_finished required one within %0d cycles", 2 * FRAME_CYC);
    end
    fcyc = cyc;
  endtask

  task automatic single(input logic [23:0] d, input logic [2:0] m, input bit tamper);
    int unsigned f;
    @(negedge clk);
    check("idle_scl", scl, 1);
    check("idle_sda", (sda_bus === 1'b0) ? 0 : 1, 1);
    data = d; nack_mask = m; start = 1'b1;
    exp_q.push_back(model(d, m, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    check("ack_err_cleared", ack_err, 0);
    if (tamper) begin
      repeat (150) begin
        @(negedge clk);
        start = 1'($urandom);
        data = 24'($urandom);
      end
      start = 1'b0;
    end
    wait_finish(f);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned f;
    repeat (3) @(negedge clk);
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda", (sda_bus === 1'b0) ? 0 : 1, 1);
    check("rst_finished", finished, 0);
    check("rst_ack_err", ack_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    single(24'h340E42, 3'b000, 1'b0);
    single(24'h340E42, 3'b001, 1'b0);
    single(24'h5A17C3, 3'b000, 1'b0);

    // back-to-back: new data presented in the o_finished cycle with start held
    @(negedge clk);
    data = 24'h340E42; nack_mask = 3'b000; start = 1'b1;
    exp_q.push_back(model(24'h340E42, 3'b000, cyc + 1));
    wait_finish(f);
    data = 24'h341201;
    exp_q.push_back(model(24'h341201, 3'b000, f + 2));
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_finish(f);
    repeat (3) @(negedge clk);

    single(24'h9C3E11, 3'b000, 1'b1);

    // reset in the middle of byte 1, bit 2 (SCL low, SDA driven low)
    @(negedge clk);
    data = 24'hA5C35A; nack_mask = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (47 * D) @(negedge clk);
    check("pre_rst_scl", scl, 0);
    check("pre_rst_sda", (sda_bus === 1'b0) ? 0 : 1, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_scl", scl, 1);
    check("midrst_sda", (sda_bus === 1'b0) ? 0 : 1, 1);
    check("midrst_finished", finished, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME_CYC) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      logic [2:0] m;
      m = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      single(24'($urandom), m, 1'($urandom_range(0, 1)) & (m == 3'b000));
    end

    repeat (10) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
